// File: rtl/fd_pipe_reg.sv
// F->D pipeline register for the 5-stage MIPS core.
// Captures the fetched PC, instruction word and delay-slot flag for the
// decode stage. It also flags illegal fetch addresses (AdEL) and applies
// the req / stall / flush controls. A saturating stall counter is kept for
// performance debug.
module fd_pipe_reg #(
   parameter logic [31:0] INSTR_START = 32'h0000_3000,
   parameter logic [31:0] INSTR_END   = 32'h0000_6ffc,
   parameter logic [31:0] EXC_ENTRY   = 32'h0000_4180,
   parameter logic [4:0]  EXC_ADEL    = 5'd4,
   parameter int          CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic             req,
   input  logic [31:0]      F_PC,
   input  logic [31:0]      F_instr,
   input  logic             F_BD,
   output logic [31:0]      D_PC,
   output logic [31:0]      D_instr,
   output logic             D_BD,
   output logic [4:0]       D_ExcCode,
   output logic             D_valid,
   output logic [CNT_W-1:0] stall_cnt
);

   // What the D stage does on the coming edge, already resolved by priority.
   typedef enum logic [1:0] {
      ACT_LOAD  = 2'd0,
      ACT_FLUSH = 2'd1,
      ACT_HOLD  = 2'd2,
      ACT_EXC   = 2'd3
   } act_e;

   // Complete D-stage contents, so that hold, bubble and load each move the
   // whole stage in one assignment.
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        bd;
      logic [4:0]  exc;
      logic        valid;
   } dstage_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   act_e             act;
   logic             fault;
   dstage_t          d_q, d_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Resolve the controls: an exception request beats stall, stall beats flush.
   always_comb begin
      if (req)        act = ACT_EXC;
      else if (stall) act = ACT_HOLD;
      else if (flush) act = ACT_FLUSH;
      else            act = ACT_LOAD;
   end

   // AdEL check: misaligned, or outside the instruction window (unsigned compare).
   always_comb begin
      fault = (F_PC[1:0] != 2'b00) || (F_PC < INSTR_START) || (F_PC > INSTR_END);
   end

   // Next D-stage contents for each action.
   always_comb begin
      // NOTE: giving d_d a default first means every path assigns it, so no latch is inferred.
      d_d = d_q;
      unique case (act)
         ACT_EXC: begin
            d_d = '{pc: EXC_ENTRY, instr: 32'h0, bd: 1'b0, exc: 5'd0, valid: 1'b0};
         end
         ACT_HOLD: begin
            d_d = d_q;
         end
         ACT_FLUSH: begin
            // The bubble keeps F_PC so CP0 can still take an EPC from D.
            d_d = '{pc: F_PC, instr: 32'h0, bd: 1'b0, exc: 5'd0, valid: 1'b0};
         end
         ACT_LOAD: begin
            // A faulting fetch still carries its PC, because CP0 needs it for EPC/BadVAddr.
            d_d.pc    = F_PC;
            d_d.bd    = F_BD;
            d_d.valid = 1'b1;
            d_d.instr = fault ? 32'h0 : F_instr;
            d_d.exc   = fault ? EXC_ADEL : 5'd0;
         end
         default: d_d = d_q;
      endcase
   end

   // Stall counter: count every stalled edge (including req+stall) and saturate.
   always_comb begin
      cnt_d = cnt_q;
      if (stall && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;
   end

   // State registers: asynchronous active-low reset to the bubble at INSTR_START.
   always_ff @(posedge clk or negedge reset) begin
      // NOTE: every register here is a control/data flop with a defined reset value; there is no memory array to leave unreset.
      if (!reset) begin
         d_q   <= '{pc: INSTR_START, instr: 32'h0, bd: 1'b0, exc: 5'd0, valid: 1'b0};
         cnt_q <= '0;
      end else begin
         // NOTE: non-blocking assignments make all flops update together from pre-edge values.
         d_q   <= d_d;
         cnt_q <= cnt_d;
      end
   end

   assign D_PC      = d_q.pc;
   assign D_instr   = d_q.instr;
   assign D_BD      = d_q.bd;
   assign D_ExcCode = d_q.exc;
   assign D_valid   = d_q.valid;
   assign stall_cnt = cnt_q;

endmodule
